// File: rtl/rv_bp_pkg.sv
// rv_bp_pkg: shared branch predictor constants and PC field extraction helpers
package rv_bp_pkg;
  localparam int PC_ALIGN = 2;
  function automatic int ctr_rst(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lo, input int w);
    return (pc >> lo) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: W-bit saturating up/down counter with configurable reset value
module bp_sat_counter #(
  parameter int W = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = !en ? cnt_q : up ? (&cnt_q ? cnt_q : cnt_q + W'(1)) : (|cnt_q ? cnt_q - W'(1) : cnt_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged BTB + PHT dynamic predictor with misprediction detection and stats.
// Define BP_GSHARE_EN to xor global history into the PHT index (gshare).
module branch_predictor
  import rv_bp_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;
  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  logic [CTR_W-1:0] pht [ENTRIES];
  logic [IDX_W-1:0] p_idx, p_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
  logic unused_pc_bits;
  assign p_idx = IDX_W'(pc_field(64'(pred_pc), PC_ALIGN, IDX_W));
  assign u_idx = IDX_W'(pc_field(64'(upd_pc), PC_ALIGN, IDX_W));
  assign p_tag = TAG_W'(pc_field(64'(pred_pc), IDX_W + PC_ALIGN, TAG_W));
  assign u_tag = TAG_W'(pc_field(64'(upd_pc), IDX_W + PC_ALIGN, TAG_W));
  assign unused_pc_bits = ^{pred_pc, upd_pc};
`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;
  // A resolved mispredict repairs history and overrides this cycle's speculative shift
  always_comb begin
    ghr_d = mispredict ? {upd_ghr[GHR_W-2:0], upd_taken}
          : (pred_valid && pred_hit) ? {ghr_q[GHR_W-2:0], pred_taken} : ghr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else ghr_q <= ghr_d;
  end
  assign p_pidx   = p_idx ^ IDX_W'(ghr_q);
  assign u_pidx   = u_idx ^ IDX_W'(upd_ghr);
  assign pred_ghr = ghr_q;
`else
  logic unused_ghr;
  assign unused_ghr = ^upd_ghr;
  assign p_pidx     = p_idx;
  assign u_pidx     = u_idx;
  assign pred_ghr   = '0;
`endif
  for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
    bp_sat_counter #(.W(CTR_W), .RST_VAL(CTR_W'(ctr_rst(CTR_W)))) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (upd_valid && u_pidx == IDX_W'(i)),
      .up    (upd_taken),
      .cnt   (pht[i])
    );
  end
  // A taken branch either refreshes its own entry or evicts whatever shares its index
  always_comb begin
    btb_d = btb_q;
    if (upd_valid && upd_taken) btb_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btb_q <= '{default: '0};
    else btb_q <= btb_d;
  end
  assign pred_hit    = btb_q[p_idx].valid && btb_q[p_idx].tag == p_tag;
  assign pred_taken  = pred_valid && pred_hit && pht[p_pidx][CTR_W-1];
  assign pred_target = pred_taken ? btb_q[p_idx].target : pred_pc + XLEN'(4);
  assign mispredict  = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  always_comb begin
    branch_cnt_d  = (upd_valid && !(&branch_cnt_q)) ? branch_cnt_q + STAT_W'(1) : branch_cnt_q;
    mispred_cnt_d = (mispredict && !(&mispred_cnt_q)) ? mispred_cnt_q + STAT_W'(1) : mispred_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks against a table-level predictor model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid, pred_hit, pred_taken;
  logic [63:0] pred_pc, pred_target;
  logic [3:0]  pred_ghr, upd_ghr;
  logic        upd_valid, upd_taken, upd_pred_taken, mispredict;
  logic [63:0] upd_pc, upd_target, upd_pred_target, redirect_pc;
  logic [31:0] branch_cnt, mispred_cnt;
  int checks = 0, failures = 0;
  bit          m_valid [16];
  logic [63:0] m_tag [16];
  logic [63:0] m_tgt [16];
  int          m_pht [16];
  longint      m_br, m_mp;

  branch_predictor dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int fidx(input logic [63:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [63:0] ftag(input logic [63:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[fidx(pc)] && m_tag[fidx(pc)] == ftag(pc);
  endfunction

  function automatic bit m_taken(input bit pv, input logic [63:0] pc);
    return pv && m_hit(pc) && m_pht[fidx(pc)] >= 2;
  endfunction

  function automatic logic [63:0] m_target(input bit pv, input logic [63:0] pc);
    return m_taken(pv, pc) ? m_tgt[fidx(pc)] : pc + 64'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_pht[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic drive_idle(input logic [63:0] ppc);
    pred_valid = 1'b1; pred_pc = ppc; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; upd_ghr = '0;
  endtask

  // Entered and left 1 time unit after a rising edge; exactly one edge in between
  task automatic cycle(input bit pv, input logic [63:0] ppc, input bit uv, input logic [63:0] upc,
                       input bit ut, input logic [63:0] utgt, input bit upt, input logic [63:0] uptgt);
    bit mp;
    int j;
    pred_valid = pv; pred_pc = ppc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt; upd_ghr = 4'($urandom);
    #2;
    mp = uv && (ut != upt || (ut && utgt != uptgt));
    check("hit", pred_hit, m_hit(ppc));
    check("taken", pred_taken, m_taken(pv, ppc));
    check("target", pred_target, m_target(pv, ppc));
    check("mispredict", mispredict, mp);
    if (mp) check("redirect", redirect_pc, ut ? utgt : upc + 64'd4);
    check("branch_cnt", branch_cnt, m_br);
    check("mispred_cnt", mispred_cnt, m_mp);
    @(posedge clk);
    if (uv) begin
      j = fidx(upc);
      m_pht[j] = ut ? (m_pht[j] < 3 ? m_pht[j] + 1 : 3) : (m_pht[j] > 0 ? m_pht[j] - 1 : 0);
      if (ut) begin
        m_valid[j] = 1;
        m_tag[j]   = ftag(upc);
        m_tgt[j]   = utgt;
      end
      m_br++;
      if (mp) m_mp++;
    end
    #1;
  endtask

  initial begin
    logic [63:0] rpc, upc, tgt;
    bit ut;
    m_reset();
    drive_idle(64'h40);
    #12;
    check("rst_hit", pred_hit, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_target", pred_target, 64'h44);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
`ifndef BP_GSHARE_EN
    check("rst_ghr", pred_ghr, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 64'h40, 0, 0, 0, 0, 0, 0);
    cycle(1, 64'h40, 1, 64'h40, 1, 64'h100, 0, 64'h44);
    check("t2_hit", pred_hit, 1);
    check("t2_taken", pred_taken, 1);
    check("t2_target", pred_target, 64'h100);
    check("t2_branch_cnt", branch_cnt, 1);
    check("t2_mispred_cnt", mispred_cnt, 1);
    for (int i = 0; i < 4; i++) cycle(1, 64'h40, 1, 64'h40, 1, 64'h100, 1, 64'h100);
    cycle(1, 64'h40, 1, 64'h40, 0, 0, 1, 64'h100);
    check("t3_nt1_taken", pred_taken, 1);
    cycle(1, 64'h40, 1, 64'h40, 0, 0, 1, 64'h100);
    check("t3_nt2_taken", pred_taken, 0);
    check("t3_nt2_target", pred_target, 64'h44);
    cycle(1, 64'h80, 0, 0, 0, 0, 0, 0);
    check("t4_alias_hit", pred_hit, 0);
    cycle(1, 64'h40, 1, 64'h80, 1, 64'h200, 0, 64'h84);
    check("t4_evict_hit", pred_hit, 0);
    cycle(1, 64'h80, 1, 64'h80, 0, 0, 1, 64'h200);
    check("t5_new_taken", pred_taken, 0);
    check("t5_new_target", pred_target, 64'h84);
    cycle(1, 64'h40, 1, 64'h40, 1, 64'h300, 1, 64'h300);
    cycle(1, 64'h40, 1, 64'h40, 1, 64'h300, 1, 64'h300);
    check("t6_pre_taken", pred_taken, 1);
    drive_idle(64'h40);
    #1;
    reset = 1'b1;
    #1;
    check("t6_hit", pred_hit, 0);
    check("t6_taken", pred_taken, 0);
    check("t6_target", pred_target, 64'h44);
    check("t6_branch_cnt", branch_cnt, 0);
    check("t6_mispred_cnt", mispred_cnt, 0);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 500; n++) begin
      rpc = {50'd0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'b00};
      upc = {50'd0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'b00};
      tgt = {54'd0, 8'($urandom_range(0, 7)), 2'b00} + 64'h1000;
      ut  = 1'($urandom);
      if ($urandom_range(0, 9) < 7)
        cycle($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 2) != 0, upc, ut, tgt,
              m_taken(1, upc), m_target(1, upc));
      else
        cycle($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 2) != 0, upc, ut, tgt,
              1'($urandom), tgt);
    end
    drive_idle(64'h40);
    #2;
    check("end_branch_cnt", branch_cnt, m_br);
    check("end_mispred_cnt", mispred_cnt, m_mp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
